fln_rr: RTL and testbench

Range-reduction front end for the natural-log datapath. It accepts IEEE-754 single-precision operands over a valid/ready handshake and splits each one as x = 2^k · m, with m in [1.0, 2.0). It emits m as a float, k as an exactly converted float, and a special-case flag/value. Downstream, m feeds the ln-series evaluator, k is multiplied by ln2 and added back, and the special flag/value bypasses both.

---
 rtl/fln_rr.sv | 202 ++++++++++++++++++++
 tb/tb_fln_rr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fln_rr.sv
// fln_rr: range-reduction front end for ln(x).
// Splits a single-precision operand into x = 2^k * m with m in [1,2).
// Stage 1 classifies the operand and registers m and an integer k.
// Stage 2 converts k to an exact float and drives the result ports.
// The two stages hold independent valid bits, so bubbles collapse and a
// full pipeline can drain, shift and accept a new operand on the same edge.
module fln_rr (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_m,
  output logic [31:0] out_k,
  output logic        out_special,
  output logic [31:0] out_sval
);

  localparam int unsigned W  = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned FW = 23;
  localparam int unsigned KW = 9;
  localparam int unsigned LW = 5;

  localparam logic [W-1:0]  QNAN     = 32'h7FC0_0000;
  localparam logic [W-1:0]  NEG_INF  = 32'hFF80_0000;
  localparam logic [W-1:0]  POS_INF  = 32'h7F80_0000;
  localparam logic [EW-1:0] EXP_BIAS = 8'd127;

  // Operand fields
  logic          in_sgn;
  logic [EW-1:0] in_exp;
  logic [FW-1:0] in_frac;

  assign in_sgn  = in_data[31];
  assign in_exp  = in_data[30:23];
  assign in_frac = in_data[22:0];

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_special_q, s1_special_d;
  logic [W-1:0]         s1_sval_q, s1_sval_d;
  logic [W-1:0]         s1_m_q, s1_m_d;
  logic signed [KW-1:0] s1_k_q, s1_k_d;

  // Stage 2 state (drives the ports)
  logic         s2_valid_q, s2_valid_d;
  logic         s2_special_q, s2_special_d;
  logic [W-1:0] s2_sval_q, s2_sval_d;
  logic [W-1:0] s2_m_q, s2_m_d;
  logic [W-1:0] s2_k_q, s2_k_d;

  // Handshake
  logic s1_load;
  logic s2_load;

  // Classification results for the incoming operand
  logic                 cls_special;
  logic [W-1:0]         cls_sval;
  logic [W-1:0]         cls_m;
  logic signed [KW-1:0] cls_k;

  // Leading-zero count of the fraction, used only for denormals
  logic [LW-1:0] lz;
  logic          lz_found;

  // Integer k to float conversion
  logic [EW-1:0] abs_k;
  logic [2:0]    k_msb;
  logic [FW-1:0] k_frac;
  logic [W-1:0]  k_float;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Count leading zeros of the 23-bit fraction
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = int'(FW) - 1; i >= 0; i--) begin
      if (!lz_found && in_frac[i]) begin
        lz       = LW'(int'(FW) - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Classify the operand and form m and integer k
  always_comb begin
    logic [FW-1:0] den_frac;
    den_frac    = '0;
    cls_special = 1'b0;
    cls_sval    = '0;
    cls_m       = '0;
    cls_k       = '0;
    if (in_exp == 8'hFF && in_frac != '0) begin
      cls_special = 1'b1;
      cls_sval    = QNAN;
    end else if (in_sgn && (in_exp != '0 || in_frac != '0)) begin
      cls_special = 1'b1;
      cls_sval    = QNAN;
    end else if (in_exp == '0 && in_frac == '0) begin
      cls_special = 1'b1;
      cls_sval    = NEG_INF;
    end else if (in_exp == 8'hFF) begin
      cls_special = 1'b1;
      cls_sval    = POS_INF;
    end else if (in_exp == '0) begin
      // Denormal: renormalise so the leading one becomes the hidden bit
      den_frac = in_frac << (lz + LW'(1));
      cls_m    = {1'b0, EXP_BIAS, den_frac};
      cls_k    = -9'sd127 - $signed({4'd0, lz});
    end else begin
      cls_m = {1'b0, EXP_BIAS, in_frac};
      cls_k = $signed({1'b0, in_exp}) - 9'sd127;
    end
  end

  // Exact int-to-float of stage-1 k; |k| <= 149 fits 8 bits
  always_comb begin
    abs_k = s1_k_q[KW-1] ? EW'(-s1_k_q) : EW'(s1_k_q);
    k_msb = '0;
    for (int i = 0; i < int'(EW); i++) begin
      if (abs_k[i]) k_msb = 3'(i);
    end
    // Pushing the MSB just past bit 22 leaves the lower bits left-aligned
    k_frac  = {abs_k, 15'd0} << (4'd8 - 4'(k_msb));
    k_float = '0;
    if (abs_k != '0) begin
      k_float = {s1_k_q[KW-1], EXP_BIAS + EW'(k_msb), k_frac};
    end
  end

  // Next-state for both stages
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_special_d = s1_special_q;
    s1_sval_d    = s1_sval_q;
    s1_m_d       = s1_m_q;
    s1_k_d       = s1_k_q;
    s2_valid_d   = s2_valid_q;
    s2_special_d = s2_special_q;
    s2_sval_d    = s2_sval_q;
    s2_m_d       = s2_m_q;
    s2_k_d       = s2_k_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_special_d = cls_special;
        s1_sval_d    = cls_sval;
        s1_m_d       = cls_m;
        s1_k_d       = cls_k;
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_special_d = s1_special_q;
        s2_sval_d    = s1_sval_q;
        s2_m_d       = s1_m_q;
        s2_k_d       = k_float;
      end
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_special_q <= 1'b0;
      s1_sval_q    <= '0;
      s1_m_q       <= '0;
      s1_k_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_special_q <= 1'b0;
      s2_sval_q    <= '0;
      s2_m_q       <= '0;
      s2_k_q       <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_special_q <= s1_special_d;
      s1_sval_q    <= s1_sval_d;
      s1_m_q       <= s1_m_d;
      s1_k_q       <= s1_k_d;
      s2_valid_q   <= s2_valid_d;
      s2_special_q <= s2_special_d;
      s2_sval_q    <= s2_sval_d;
      s2_m_q       <= s2_m_d;
      s2_k_q       <= s2_k_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_special = s2_special_q;
  assign out_sval    = s2_sval_q;
  assign out_m       = s2_m_q;
  assign out_k       = s2_k_q;

endmodule

// File: tb/tb_fln_rr.sv
// Directed bench for fln_rr: single operands, specials, backpressure, reset.
module tb_fln_rr;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_m;
  logic [31:0] out_k;
  logic        out_special;
  logic [31:0] out_sval;

  int total;
  int bad;

  fln_rr dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_m      (out_m),
    .out_k      (out_k),
    .out_special(out_special),
    .out_sval   (out_sval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one operand into an empty pipe and check the result two edges on
  task automatic run_one(input string tag, input logic [31:0] din,
                         input logic [31:0] em, input logic [31:0] ek,
                         input logic esp, input logic [31:0] esv);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_m"}, out_m, em);
    check({tag, "_k"}, out_k, ek);
    check({tag, "_special"}, 32'(out_special), 32'(esp));
    check({tag, "_sval"}, out_sval, esv);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_m", out_m, 32'd0);
    check("rst_k", out_k, 32'd0);
    check("rst_special", 32'(out_special), 32'd0);
    check("rst_sval", out_sval, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Normals
    run_one("two",   32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0);
    run_one("one",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h0);
    run_one("onep5", 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000, 1'b0, 32'h0);
    run_one("maxn",  32'h7F7F_FFFF, 32'h3FFF_FFFF, 32'h42FE_0000, 1'b0, 32'h0);
    // Denormals: smallest and largest-exponent cases
    run_one("den_lo", 32'h0000_0001, 32'h3F80_0000, 32'hC315_0000, 1'b0, 32'h0);
    run_one("den_hi", 32'h0040_0000, 32'h3F80_0000, 32'hC2FE_0000, 1'b0, 32'h0);
    // Specials
    run_one("neg1",  32'hBF80_0000, 32'h0, 32'h0, 1'b1, 32'h7FC0_0000);
    run_one("nzero", 32'h8000_0000, 32'h0, 32'h0, 1'b1, 32'hFF80_0000);
    run_one("pzero", 32'h0000_0000, 32'h0, 32'h0, 1'b1, 32'hFF80_0000);
    run_one("pinf",  32'h7F80_0000, 32'h0, 32'h0, 1'b1, 32'h7F80_0000);
    run_one("ninf",  32'hFF80_0000, 32'h0, 32'h0, 1'b1, 32'h7FC0_0000);
    run_one("nan",   32'h7FC0_0001, 32'h0, 32'h0, 1'b1, 32'h7FC0_0000);

    // Backpressure: 1.0, 2.0, 4.0, 8.0 back-to-back with a stall
    in_valid  = 1'b1;
    in_data   = 32'h3F80_0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data   = 32'h4000_0000;
    out_ready = 1'b0;
    check("bp_ready_s2_empty", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = 32'h4080_0000;
    check("bp_ready_full", 32'(in_ready), 32'd0);
    check("bp_valid0", 32'(out_valid), 32'd1);
    check("bp_k0", out_k, 32'h0000_0000);
    check("bp_m0", out_m, 32'h3F80_0000);
    @(posedge clk); #1;
    check("bp_ready_hold1", 32'(in_ready), 32'd0);
    check("bp_k0_hold1", out_k, 32'h0000_0000);
    check("bp_valid_hold1", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_ready_hold2", 32'(in_ready), 32'd0);
    check("bp_k0_hold2", out_k, 32'h0000_0000);
    check("bp_m0_hold2", out_m, 32'h3F80_0000);
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_k1", out_k, 32'h3F80_0000);
    check("bp_valid1", 32'(out_valid), 32'd1);
    in_data = 32'h4100_0000;
    @(posedge clk); #1;
    check("bp_k2", out_k, 32'h4000_0000);
    check("bp_valid2", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk); #1;
    check("bp_k3", out_k, 32'h4040_0000);
    check("bp_valid3", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-stream with two items in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3F80_0000;
    @(posedge clk); #1;
    in_data = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    check("mr_pre_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mr_valid_async", 32'(out_valid), 32'd0);
    check("mr_k_async", out_k, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd1);
    run_one("mr_next", 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000, 1'b0, 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_no_stale", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
